// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Shares the single-port instruction memory between the core fetch port and
// the program loader/debug port. At most one access is granted per cycle.
// Contended cycles are decided round-robin. The loader can lock the memory
// for atomic image loads. Read data returns one cycle after the grant and is
// routed to the requester that owned that grant.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   fetch_req_i/addr_i     core fetch request (read only)
//   fetch_gnt_o            fetch accepted this cycle
//   fetch_rvalid_o/rdata_o fetch read response (1 cycle after grant)
//   ldr_req_i/we_i/lock_i  loader request, write/read select, lock request
//   ldr_addr_i/wdata_i/be_i loader payload
//   ldr_gnt_o              loader accepted this cycle
//   ldr_rvalid_o/rdata_o   loader response; rdata is 0 for write acks
//   mem_*_o                memory strobe, write enable, byte enables, word
//                          address, write data (mirror the granted requester)
//   mem_rdata_i            memory read data, valid 1 cycle after mem_en_o
//   locked_o               loader lock active, fetch blocked
// ---------------------------------------------------------------------------
module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      fetch_req_i,
  input  logic [ADDR_WIDTH-1:0]     fetch_addr_i,
  output logic                      fetch_gnt_o,
  output logic                      fetch_rvalid_o,
  output logic [DATA_WIDTH-1:0]     fetch_rdata_o,
  input  logic                      ldr_req_i,
  input  logic                      ldr_we_i,
  input  logic                      ldr_lock_i,
  input  logic [ADDR_WIDTH-1:0]     ldr_addr_i,
  input  logic [DATA_WIDTH-1:0]     ldr_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   ldr_be_i,
  output logic                      ldr_gnt_o,
  output logic                      ldr_rvalid_o,
  output logic [DATA_WIDTH-1:0]     ldr_rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [ADDR_WIDTH-3:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      locked_o
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  lock_state_e r_state;
  lock_state_e w_state_nxt;
  owner_e      r_last;
  logic        r_rsp_valid;
  owner_e      r_rsp_owner;
  logic        r_rsp_we;

  logic        w_lock_active;
  logic        w_fetch_gnt;
  logic        w_ldr_gnt;
  logic        w_unused_addr_bits;

  // Word addressing: the two byte-offset bits are intentionally dropped.
  assign w_unused_addr_bits = ^{fetch_addr_i[1:0], ldr_addr_i[1:0]};

  // The lock only blocks fetch while the loader keeps ldr_lock_i high; the
  // cycle it drops, normal arbitration applies so fetch can win immediately.
  assign w_lock_active = (r_state == ST_LOCKED) && ldr_lock_i;

  // Grant and next-state logic. Grants are gated by rst_ni so that every
  // grant and memory strobe is low while reset is held.
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_ldr_gnt   = 1'b0;
    w_state_nxt = r_state;

    if (rst_ni) begin
      if (w_lock_active) begin
        w_ldr_gnt = ldr_req_i;
      end else if (fetch_req_i && ldr_req_i) begin
        if (r_last == OWN_LOADER) begin
          w_fetch_gnt = 1'b1;
        end else begin
          w_ldr_gnt = 1'b1;
        end
      end else begin
        w_fetch_gnt = fetch_req_i;
        w_ldr_gnt   = ldr_req_i;
      end
    end

    case (r_state)
      ST_UNLOCKED: if (ldr_lock_i && w_ldr_gnt) w_state_nxt = ST_LOCKED;
      ST_LOCKED:   if (!ldr_lock_i)             w_state_nxt = ST_UNLOCKED;
      default:                                  w_state_nxt = ST_UNLOCKED;
    endcase
  end

  // Memory port mirrors whichever requester is granted.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_fetch_gnt) begin
      mem_en_o   = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = fetch_addr_i[ADDR_WIDTH-1:2];
    end else if (w_ldr_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ldr_we_i;
      mem_be_o    = ldr_we_i ? ldr_be_i : '1;
      mem_addr_o  = ldr_addr_i[ADDR_WIDTH-1:2];
      mem_wdata_o = ldr_we_i ? ldr_wdata_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_UNLOCKED;
      r_last      <= OWN_LOADER;
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWN_FETCH;
      r_rsp_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_fetch_gnt || w_ldr_gnt;
      if (w_fetch_gnt) begin
        r_last      <= OWN_FETCH;
        r_rsp_owner <= OWN_FETCH;
        r_rsp_we    <= 1'b0;
      end else if (w_ldr_gnt) begin
        r_last      <= OWN_LOADER;
        r_rsp_owner <= OWN_LOADER;
        r_rsp_we    <= ldr_we_i;
      end
    end
  end

  always_comb begin
    fetch_rvalid_o = r_rsp_valid && (r_rsp_owner == OWN_FETCH);
    ldr_rvalid_o   = r_rsp_valid && (r_rsp_owner == OWN_LOADER);
    fetch_rdata_o  = (fetch_rvalid_o && !r_rsp_we) ? mem_rdata_i : '0;
    ldr_rdata_o    = (ldr_rvalid_o && !r_rsp_we) ? mem_rdata_i : '0;
  end

  assign fetch_gnt_o = w_fetch_gnt;
  assign ldr_gnt_o   = w_ldr_gnt;
  assign locked_o    = w_lock_active;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt, fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        ldr_req, ldr_we, ldr_lock;
  logic [31:0] ldr_addr, ldr_wdata;
  logic [3:0]  ldr_be;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        locked;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
    .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_lock_i(ldr_lock),
    .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata), .ldr_be_i(ldr_be),
    .ldr_gnt_o(ldr_gnt), .ldr_rvalid_o(ldr_rvalid), .ldr_rdata_o(ldr_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .locked_o(locked)
  );

  // Single-port synchronous memory: write at the grant edge, read data one
  // cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:0]];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step();
    fetch_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0; ldr_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    fetch_req = 1'b1; fetch_addr = 32'h44;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_lock = 1'b0;
    ldr_addr = 32'h48; ldr_wdata = 32'h12345678; ldr_be = 4'hF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({fetch_gnt, fetch_rvalid, ldr_gnt, ldr_rvalid, mem_en, mem_we, locked} !== 7'b0) begin
        failures++;
        $display("FAIL reset_ctrl: got fg=%b frv=%b lg=%b lrv=%b en=%b we=%b lk=%b expected all 0",
                 fetch_gnt, fetch_rvalid, ldr_gnt, ldr_rvalid, mem_en, mem_we, locked);
      end
      checks++;
      if ({fetch_rdata, ldr_rdata, mem_be, mem_addr, mem_wdata} !== '0) begin
        failures++;
        $display("FAIL reset_data: got frd=%h lrd=%h be=%h addr=%h wd=%h expected all 0",
                 fetch_rdata, ldr_rdata, mem_be, mem_addr, mem_wdata);
      end
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({fetch_gnt, ldr_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_gnt: got fg=%b lg=%b expected fg=1 lg=0", fetch_gnt, ldr_gnt);
    end
    checks++;
    if (mem_addr !== 30'h11 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
      failures++;
      $display("FAIL reset_fetch_mem: got addr=%h we=%b be=%h expected addr=11 we=0 be=f",
               mem_addr, mem_we, mem_be);
    end
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 5; i++) begin
      step();
      fetch_req  = (i < 4);
      fetch_addr = 32'(4 * i);
      @(negedge clk);
      checks++;
      if (fetch_gnt !== (i < 4)) begin
        failures++;
        $display("FAIL stream_gnt[%0d]: got %b expected %b", i, fetch_gnt, (i < 4));
      end
      checks++;
      if (i == 0) begin
        if (fetch_rvalid !== 1'b0) begin
          failures++;
          $display("FAIL stream_rvalid[0]: got %b expected 0", fetch_rvalid);
        end
      end else if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'(32'h1000 + i - 1)) begin
        failures++;
        $display("FAIL stream_rdata[%0d]: got rv=%b data=%h expected rv=1 data=%h",
                 i, fetch_rvalid, fetch_rdata, 32'h1000 + i - 1);
      end
    end
  endtask

  task automatic test_contention();
    logic prev_f;
    logic [31:0] prev_d;
    logic exp_f, exp_l;
    step();
    fetch_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h0;
    @(negedge clk);
    checks++;
    if ({fetch_gnt, ldr_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL cont_solo_ldr: got fg=%b lg=%b expected fg=0 lg=1", fetch_gnt, ldr_gnt);
    end
    prev_f = 1'b0; prev_d = 32'h1000;
    for (int k = 0; k < 7; k++) begin
      step();
      fetch_req = (k < 6); ldr_req = (k < 6);
      fetch_addr = 32'h4; ldr_addr = 32'h8;
      @(negedge clk);
      exp_f = (k < 6) && (k % 2 == 0);
      exp_l = (k < 6) && (k % 2 == 1);
      checks++;
      if (fetch_gnt !== exp_f || ldr_gnt !== exp_l) begin
        failures++;
        $display("FAIL cont_gnt[%0d]: got fg=%b lg=%b expected fg=%b lg=%b",
                 k, fetch_gnt, ldr_gnt, exp_f, exp_l);
      end
      checks++;
      if (fetch_rvalid !== prev_f || ldr_rvalid !== !prev_f ||
          fetch_rdata !== (prev_f ? prev_d : 32'h0) ||
          ldr_rdata !== (prev_f ? 32'h0 : prev_d)) begin
        failures++;
        $display("FAIL cont_rsp[%0d]: got frv=%b frd=%h lrv=%b lrd=%h expected owner=%s data=%h",
                 k, fetch_rvalid, fetch_rdata, ldr_rvalid, ldr_rdata,
                 prev_f ? "fetch" : "loader", prev_d);
      end
      prev_f = exp_f;
      prev_d = exp_f ? 32'h1001 : 32'h1002;
    end
  endtask

  task automatic test_ldr_write_read();
    step();
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h40;
    ldr_wdata = 32'hDEADBEEF; ldr_be = 4'b0011;
    @(negedge clk);
    checks++;
    if (ldr_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 ||
        mem_addr !== 30'h10 || mem_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_mem: got gnt=%b en=%b we=%b be=%b addr=%h wd=%h expected 1 1 1 0011 10 deadbeef",
               ldr_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
    step();
    ldr_we = 1'b0;
    @(negedge clk);
    checks++;
    if (ldr_rvalid !== 1'b1 || ldr_rdata !== 32'h0) begin
      failures++;
      $display("FAIL wr_ack: got rv=%b rd=%h expected rv=1 rd=0", ldr_rvalid, ldr_rdata);
    end
    checks++;
    if (ldr_gnt !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
      failures++;
      $display("FAIL rd_mem: got gnt=%b we=%b be=%h expected gnt=1 we=0 be=f", ldr_gnt, mem_we, mem_be);
    end
    step();
    ldr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ldr_rvalid !== 1'b1 || ldr_rdata !== 32'hFFFFBEEF) begin
      failures++;
      $display("FAIL rd_data: got rv=%b rd=%h expected rv=1 rd=ffffbeef", ldr_rvalid, ldr_rdata);
    end
  endtask

  task automatic test_lock();
    logic       t_req  [0:4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       t_lock [0:4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       e_fg   [0:4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       e_lk   [0:4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       prev_lg;
    step();
    fetch_req = 1'b1; fetch_addr = 32'h0; ldr_req = 1'b0; ldr_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_gnt !== 1'b1) begin
      failures++;
      $display("FAIL lock_pre_fetch: got fg=%b expected 1", fetch_gnt);
    end
    prev_lg = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      ldr_req = t_req[c]; ldr_lock = t_lock[c]; ldr_we = 1'b1; ldr_be = 4'hF;
      ldr_addr = 32'(32'h80 + 4 * c); ldr_wdata = 32'(32'hC0DE0000 + c);
      @(negedge clk);
      checks++;
      if (fetch_gnt !== e_fg[c] || ldr_gnt !== t_req[c] || locked !== e_lk[c]) begin
        failures++;
        $display("FAIL lock_cyc[%0d]: got fg=%b lg=%b lk=%b expected fg=%b lg=%b lk=%b",
                 c, fetch_gnt, ldr_gnt, locked, e_fg[c], t_req[c], e_lk[c]);
      end
      checks++;
      if (ldr_rvalid !== prev_lg || ldr_rdata !== 32'h0) begin
        failures++;
        $display("FAIL lock_ack[%0d]: got rv=%b rd=%h expected rv=%b rd=0", c, ldr_rvalid, ldr_rdata, prev_lg);
      end
      prev_lg = t_req[c];
    end
    step();
    fetch_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h8C;
    @(negedge clk);
    checks++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h1000) begin
      failures++;
      $display("FAIL lock_fetch_rsp: got rv=%b rd=%h expected rv=1 rd=1000", fetch_rvalid, fetch_rdata);
    end
    step();
    ldr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ldr_rdata !== 32'hC0DE0003) begin
      failures++;
      $display("FAIL lock_readback: got %h expected c0de0003", ldr_rdata);
    end
  endtask

  task automatic test_lock_no_req();
    for (int c = 0; c < 2; c++) begin
      step();
      fetch_req = 1'b1; fetch_addr = 32'h4; ldr_req = 1'b0; ldr_lock = 1'b1;
      @(negedge clk);
      checks++;
      if (fetch_gnt !== 1'b1 || locked !== 1'b0) begin
        failures++;
        $display("FAIL lock_noreq[%0d]: got fg=%b lk=%b expected fg=1 lk=0", c, fetch_gnt, locked);
      end
    end
  endtask

  task automatic test_mid_reset();
    step();
    fetch_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0; ldr_lock = 1'b1; ldr_addr = 32'h0;
    @(negedge clk);
    checks++;
    if (ldr_gnt !== 1'b1) begin
      failures++;
      $display("FAIL mrst_gnt: got lg=%b expected 1", ldr_gnt);
    end
    step();
    ldr_req = 1'b0; ldr_lock = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ldr_rvalid !== 1'b0 || ldr_rdata !== 32'h0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL mrst_in_reset: got rv=%b rd=%h lk=%b expected 0 0 0", ldr_rvalid, ldr_rdata, locked);
    end
    step();
    rst_n = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h8; ldr_lock = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_gnt !== 1'b1 || locked !== 1'b0 || ldr_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL mrst_release: got fg=%b lk=%b lrv=%b expected fg=1 lk=0 lrv=0",
               fetch_gnt, locked, ldr_rvalid);
    end
    step();
    fetch_req = 1'b0; ldr_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_rvalid !== 1'b1 || fetch_rdata !== 32'h1002 || ldr_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL mrst_after: got frv=%b frd=%h lrv=%b expected 1 1002 0",
               fetch_rvalid, fetch_rdata, ldr_rvalid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(32'h1000 + i);
    mem[16]   = 32'hFFFFFFFF;
    mem_rdata = '0;
    test_reset();
    idle();
    test_fetch_stream();
    idle();
    test_contention();
    idle();
    test_ldr_write_read();
    idle();
    test_lock();
    idle();
    test_lock_no_req();
    idle();
    test_mid_reset();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter sharing the single-port instruction memory between the core fetch port and the program loader/debug port. Sits between `core` (fetch side, currently wired straight to the icache read port) and the memory macro. Grants at most one access per cycle with round-robin fairness, plus a loader lock mode for atomic image loads. Read data returns on a fixed 1-cycle latency and is routed back to the granted requester.

## Interface
- `ADDR_WIDTH`, 32, byte address width; bits [1:0] ignored (word access)
- `DATA_WIDTH`, 32, memory word width; `DATA_WIDTH/8` byte enables
- `clk_i`  in  1  clock, all state on rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `fetch_req_i`  in  1  core fetch request (read only)
- `fetch_addr_i`  in  ADDR_WIDTH  fetch byte address
- `fetch_gnt_o`  out  1  fetch request accepted this cycle
- `fetch_rvalid_o`  out  1  fetch read data valid
- `fetch_rdata_o`  out  DATA_WIDTH  fetch read data
- `ldr_req_i`  in  1  loader request
- `ldr_we_i`  in  1  loader write (1) / read (0)
- `ldr_lock_i`  in  1  loader exclusive-access request
- `ldr_addr_i`  in  ADDR_WIDTH  loader byte address
- `ldr_wdata_i`  in  DATA_WIDTH  loader write data
- `ldr_be_i`  in  DATA_WIDTH/8  loader byte enables
- `ldr_gnt_o`  out  1  loader request accepted
- `ldr_rvalid_o`  out  1  loader response (read data or write ack)
- `ldr_rdata_o`  out  DATA_WIDTH  loader read data; 0 for write acks
- `mem_en_o`  out  1  memory access strobe
- `mem_we_o`  out  1  memory write enable
- `mem_be_o`  out  DATA_WIDTH/8  memory byte enables; all-ones on reads
- `mem_addr_o`  out  ADDR_WIDTH-2  word address (`addr[ADDR_WIDTH-1:2]`)
- `mem_wdata_o`  out  DATA_WIDTH  memory write data
- `mem_rdata_i`  in  DATA_WIDTH  memory read data, valid 1 cycle after `mem_en_o`
- `locked_o`  out  1  loader lock active (fetch blocked)

## Operation
- Requests: requester holds `req` and payload stable until `gnt`; `gnt` is a single-cycle accept. No backpressure on responses.
- Arbitration (state UNLOCKED): only one requesting -> grant it. Both requesting -> grant the one not granted last (`last_q`). `last_q` updates only on a grant. Reset value `last_q` = LOADER, so fetch wins the first tie.
- Memory outputs combinationally mirror the granted requester; no grant -> `mem_en_o`=0, `mem_we_o`=0, `mem_be_o`=0, `mem_addr_o`/`mem_wdata_o`=0.
- Fetch grant always drives `mem_we_o`=0, `mem_be_o`=all-ones.
- Response tracking: registers `rsp_valid_q`, `rsp_owner_q`, `rsp_we_q` capture each grant. Next cycle: owner's `rvalid`=1; `rdata` = `mem_rdata_i` for reads, 0 for write acks; non-owner `rdata`=0.
- Lock FSM: UNLOCKED -> LOCKED when `ldr_lock_i`=1 and `ldr_gnt_o`=1 (that grant counts). In LOCKED: `fetch_gnt_o`=0, loader granted whenever `ldr_req_i`=1, `locked_o`=1. LOCKED -> UNLOCKED on the first cycle `ldr_lock_i`=0; fetch may be granted that same cycle.
- Lock asserted without a loader request does not enter LOCKED and does not block fetch.

## Timing
- Grant: combinational, same cycle as `req` (0-cycle latency when uncontested).
- Read latency: `rvalid` exactly 1 cycle after `gnt`; throughput 1 access/cycle, back-to-back grants allowed.
- Write: memory updated at the grant edge; ack 1 cycle later.
- Both requesting continuously, UNLOCKED: grants alternate every cycle, F, L, F, L...
- Reset (asynchronous, any cycle): all `gnt`/`rvalid`/`mem_en_o`/`locked_o` = 0, all data outputs 0, FSM = UNLOCKED, `last_q` = LOADER. A response pending at reset is dropped (no `rvalid` after release). First grant is possible in the first cycle after release.

## Test plan
- Reset: hold `rst_ni`=0 with both reqs high -> every output 0; release -> first cycle `fetch_gnt_o`=1, `ldr_gnt_o`=0.
- Fetch streaming: mem preloaded word[i]=0x1000+i, fetch addr 0,4,8,12 every cycle -> gnt 4 consecutive cycles, `fetch_rdata_o` 0x1000..0x1003 each one cycle after its gnt.
- Contention: both req for 6 cycles -> grants F,L,F,L,F,L; each `rvalid` goes only to the grant owner.
- Loader write/read: write 0xDEADBEEF to 0x40 with be=4'b0011 over 0xFFFFFFFF -> ack with rdata 0; read 0x40 -> 0xFFFFBEEF.
- Lock: `ldr_lock_i`=1 with 3 loader writes while fetch requests -> `fetch_gnt_o`=0 and `locked_o`=1 until lock drops; fetch granted the cycle lock drops.
- Mid-transfer reset: assert `rst_ni`=0 the cycle after a loader read gnt -> no `ldr_rvalid_o`; FSM UNLOCKED after release.
